// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants: reset/trap vectors, next-PC source encodings
// and the 31-bit address add that keeps the kernel bit.
package cpu_pkg;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_JR     = 2'b11;

    // Address arithmetic wraps within [30:0]; bit 31 (kernel) is never carried into.
    function automatic logic [31:0] pc_add(input logic [31:0] base, input logic [30:0] off);
        pc_add = {base[31], base[30:0] + off};
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Timer-interrupt edge detector and pending latch: a rising edge sets pending,
// clr drops it; edges arriving while already pending are absorbed.
module irq_edge_latch
(
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic clr,
    output logic pending
);

    logic prev_q, prev_d;
    logic pending_q, pending_d;
    logic set;

    always_comb begin
        prev_d    = irq;
        set       = irq & ~prev_q;
        pending_d = pending_q;
        if (clr) begin
            pending_d = 1'b0;
        end else if (set) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter with next-PC mux and trap vectoring (illegal op, timer irq).
// Define PC_ALIGN_TRAP_EN to trap misaligned jr targets instead of masking them.
module pc_fetch
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] jr_addr,
    input  logic        irq,
    input  logic        illop,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap,
    output logic [31:0] epc,
    output logic        kernel
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] seq_pc;
    logic [31:0] jr_tgt;
    logic [30:0] br_off;
    logic        align_fault;
    logic        pending_irq;
    logic        irq_take;

    irq_edge_latch u_irq_edge_latch (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .clr     (irq_take),
        .pending (pending_irq)
    );

    always_comb begin
        seq_pc = pc_add(pc_q, 31'd4);
        br_off = {{13{imm16[15]}}, imm16, 2'b00};
`ifdef PC_ALIGN_TRAP_EN
        jr_tgt      = {pc_q[31] & jr_addr[31], jr_addr[30:0]};
        align_fault = (pc_sel == PC_SEL_JR) && (jr_addr[1:0] != 2'b00);
`else
        jr_tgt      = {pc_q[31] & jr_addr[31], jr_addr[30:2], jr_addr[1:0] & 2'b00};
        align_fault = 1'b0;
`endif
    end

    // Priority: illop, misaligned jr, pending irq in user mode, stall, pc_sel.
    always_comb begin
        pc_d     = pc_q;
        trap     = 1'b0;
        epc      = 32'd0;
        irq_take = 1'b0;
        if (illop || align_fault) begin
            pc_d = EXC_VEC;
            trap = 1'b1;
            epc  = seq_pc;
        end else if (pending_irq && !pc_q[31]) begin
            pc_d     = IRQ_VEC;
            trap     = 1'b1;
            epc      = pc_q;
            irq_take = 1'b1;
        end else if (!stall) begin
            unique case (pc_sel)
                PC_SEL_SEQ:    pc_d = seq_pc;
                PC_SEL_BRANCH: pc_d = branch_taken ? pc_add(seq_pc, br_off) : seq_pc;
                PC_SEL_JUMP:   pc_d = {pc_q[31:28], target26, 2'b00};
                PC_SEL_JR:     pc_d = jr_tgt;
                default:       pc_d = seq_pc;
            endcase
        end
        // Reset wins over anything in flight this cycle.
        if (reset) begin
            trap     = 1'b0;
            epc      = 32'd0;
            irq_take = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = seq_pc;
    assign kernel   = pc_q[31];

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed scenarios then random traffic,
// checked against a behavioural model of the fetch rules.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] jr_addr;
    logic        irq;
    logic        illop;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] epc;
    logic        kernel;

    pc_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .target26     (target26),
        .jr_addr      (jr_addr),
        .irq          (irq),
        .illop        (illop),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .trap         (trap),
        .epc          (epc),
        .kernel       (kernel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic [97:0] vec;
        bit          c_pc;
        logic [31:0] k_pc;
        bit          c_trap;
        logic        k_trap;
        bit          c_epc;
        logic [31:0] k_epc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_no = 0;

    logic [31:0] m_pc;
    bit          m_pend;
    bit          m_prev;

    function automatic logic [31:0] keep31(input logic [31:0] base, input logic [31:0] sum);
        return (sum & 32'h7FFF_FFFF) | (base & 32'h8000_0000);
    endfunction

    function automatic void check(input bit ok, input string what, input int stp,
                                  input logic [97:0] act, input logic [97:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s step %0d: got %h required %h", what, stp, act, req);
    endfunction

    // Compute this cycle's expected outputs, queue them, and advance the model one edge.
    task automatic commit(input bit cpc = 0, input logic [31:0] kpc = 0,
                          input bit ctr = 0, input logic ktr = 0,
                          input bit cep = 0, input logic [31:0] kep = 0);
        exp_t        e;
        logic [31:0] p4, nxt, e_epc;
        logic        e_trap;
        bit          taken;
        bit          misaligned;
        int          off;
        p4     = keep31(m_pc, m_pc + 32'd4);
        nxt    = m_pc;
        e_trap = 1'b0;
        e_epc  = 32'd0;
        taken  = 1'b0;
`ifdef PC_ALIGN_TRAP_EN
        misaligned = (pc_sel == 2'b11) && (jr_addr[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        if (!reset) begin
            if (illop || misaligned) begin
                nxt = 32'h8000_0008; e_trap = 1'b1; e_epc = p4;
            end else if (m_pend && !m_pc[31]) begin
                nxt = 32'h8000_0004; e_trap = 1'b1; e_epc = m_pc; taken = 1'b1;
            end else if (!stall) begin
                case (pc_sel)
                    2'b00: nxt = p4;
                    2'b01: begin
                        off = int'($signed(imm16)) * 4;
                        nxt = branch_taken ? keep31(p4, p4 + 32'(off)) : p4;
                    end
                    2'b10: nxt = (m_pc & 32'hF000_0000) | (32'(target26) << 2);
                    default: begin
                        nxt = m_pc[31] ? jr_addr : (jr_addr & 32'h7FFF_FFFF);
`ifndef PC_ALIGN_TRAP_EN
                        nxt = nxt & ~32'd3;
`endif
                    end
                endcase
            end
        end
        e.step   = step_no;
        e.vec    = {m_pc, p4, e_trap, e_epc, m_pc[31]};
        e.c_pc   = cpc;  e.k_pc   = kpc;
        e.c_trap = ctr;  e.k_trap = ktr;
        e.c_epc  = cep;  e.k_epc  = kep;
        exp_q.push_back(e);
        if (reset) begin
            m_pc = 32'h8000_0000; m_pend = 1'b0; m_prev = 1'b0;
        end else begin
            m_pend = taken ? 1'b0 : (m_pend || (irq && !m_prev));
            m_prev = irq;
            m_pc   = nxt;
        end
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; pc_sel = 2'b00; branch_taken = 0; imm16 = 0;
        target26 = 0; jr_addr = 0; irq = 0; illop = 0;
    endtask

    // Monitor: outputs are valid every cycle, so compare at each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({pc, pc_plus4, trap, epc, kernel} === e.vec, "outputs", e.step,
                      {pc, pc_plus4, trap, epc, kernel}, e.vec);
                if (e.c_pc)   check(pc === e.k_pc, "pc_const", e.step, 98'(pc), 98'(e.k_pc));
                if (e.c_trap) check(trap === e.k_trap, "trap_const", e.step, 98'(trap), 98'(e.k_trap));
                if (e.c_epc)  check(epc === e.k_epc, "epc_const", e.step, 98'(epc), 98'(e.k_epc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1;
        m_pc = 32'h8000_0000; m_pend = 0; m_prev = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset overrides illop, stall and an irq edge in the same cycle.
        illop = 1; stall = 1; irq = 1;
        commit(1, 32'h8000_0000, 1, 1'b0, 1, 32'h0);
        idle();
        commit(1, 32'h8000_0000);
        commit(1, 32'h8000_0004);
        commit(1, 32'h8000_0008);
        pc_sel = 2'b11; jr_addr = 32'h0000_0060;
        commit(1, 32'h8000_000C);
        // Branch taken backwards, then not taken.
        pc_sel = 2'b01; branch_taken = 1; imm16 = 16'hFFFD;
        commit(1, 32'h0000_0060);
        pc_sel = 2'b11; jr_addr = 32'h0000_0060;
        commit(1, 32'h0000_0058);
        pc_sel = 2'b01; branch_taken = 0;
        commit(1, 32'h0000_0060);
        // User-mode irq edge: pending next edge, taken the cycle after.
        pc_sel = 2'b00; irq = 1;
        commit(1, 32'h0000_0064, 1, 1'b0);
        irq = 0; stall = 1;
        commit(1, 32'h0000_0068, 1, 1'b1, 1, 32'h0000_0068);
        stall = 0; pc_sel = 2'b10; target26 = 26'h30;
        commit(1, 32'h8000_0004, 1, 1'b0);
        // Kernel-mode irq edge waits until jr drops to user mode.
        pc_sel = 2'b11; jr_addr = 32'h0000_0024; irq = 1;
        commit(1, 32'h8000_00C0, 1, 1'b0);
        irq = 0; pc_sel = 2'b00;
        commit(1, 32'h0000_0024, 1, 1'b1, 1, 32'h0000_0024);
        // Illop beats a pending irq; pending survives the exception and a stall.
        pc_sel = 2'b11; jr_addr = 32'h0000_0010; irq = 1;
        commit(1, 32'h8000_0004, 1, 1'b0);
        irq = 0; illop = 1; pc_sel = 2'b00;
        commit(1, 32'h0000_0010, 1, 1'b1, 1, 32'h0000_0014);
        illop = 0; stall = 1; pc_sel = 2'b10; target26 = 26'h3FF_FFFF;
        commit(1, 32'h8000_0008, 1, 1'b0);
        stall = 0; pc_sel = 2'b11; jr_addr = 32'h0000_0040;
        commit(1, 32'h8000_0008);
        pc_sel = 2'b00;
        commit(1, 32'h0000_0040, 1, 1'b1, 1, 32'h0000_0040);
        // Misaligned jr target from kernel mode.
        pc_sel = 2'b11; jr_addr = 32'h0000_0026;
`ifdef PC_ALIGN_TRAP_EN
        commit(1, 32'h8000_0004, 1, 1'b1, 1, 32'h8000_0008);
        pc_sel = 2'b00;
        commit(1, 32'h8000_0008);
`else
        commit(1, 32'h8000_0004, 1, 1'b0, 1, 32'h0);
        pc_sel = 2'b11; jr_addr = 32'hFFFF_FFFC;
        commit(1, 32'h0000_0024);
        pc_sel = 2'b00;
        commit(1, 32'h7FFF_FFFC);
`endif
        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom % 64) == 0;
            illop        = ($urandom % 16) == 0;
            stall        = ($urandom % 4) == 0;
            irq          = ($urandom % 3) == 0;
            pc_sel       = 2'($urandom);
            branch_taken = 1'($urandom);
            imm16        = 16'($urandom);
            target26     = 26'($urandom);
            jr_addr      = $urandom;
            if ($urandom % 2) jr_addr[1:0] = 2'b00;
            commit();
        end
        idle();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) check(1'b0, "drain", step_no, 98'(exp_q.size()), 98'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The module SHALL have ports clk (in, 1, sole clock, rising edge) and reset (in, 1, synchronous, active-high); no other clock or reset exists.
REQ-002 The module SHALL have ports stall (in, 1, hold PC) and pc_sel (in, 2, next-PC source: 00 seq, 01 branch, 10 jump, 11 jr).
REQ-003 The module SHALL have ports branch_taken (in, 1, branch condition true), imm16 (in, 16, branch offset), target26 (in, 26, J/JAL field) and jr_addr (in, 32, rs value).
REQ-004 The module SHALL have ports irq (in, 1, timer interrupt, synchronous to clk) and illop (in, 1, decoder flags unknown opcode).
REQ-005 The module SHALL have ports pc (out, 32, instruction address; bit 31 = kernel bit, ROM indexes pc[30:2]) and pc_plus4 (out, 32, JAL link value).
REQ-006 The module SHALL have ports trap (out, 1, vectoring this cycle: write epc to $k0, squash the instruction), epc (out, 32, return address) and kernel (out, 1, equal to pc[31]).

Function
REQ-007 pc SHALL be a register; pc_plus4 = pc+4 computed on bits [30:0] with bit 31 copied from pc.
REQ-008 The next-PC priority SHALL be: reset, illop, pending irq, stall, pc_sel.
REQ-009 Seq SHALL load pc_plus4.
REQ-010 Branch SHALL load pc_plus4 + (sign-extended imm16 << 2) when branch_taken=1 (31-bit add, bit 31 kept), else pc_plus4.
REQ-011 Jump SHALL load {pc[31:28], target26, 00}.
REQ-012 Jr SHALL load {pc[31] & jr_addr[31], jr_addr[30:0]}: kernel may drop to user mode; user mode can never raise bit 31.
REQ-013 illop=1 SHALL load 0x80000008 with trap=1 and epc=pc_plus4, regardless of stall or kernel mode.
REQ-014 An irq rising edge (irq=1, previous-cycle irq=0) SHALL set pending_irq on the next clock edge.
REQ-015 When pending_irq=1, kernel=0 and illop=0, the module SHALL load 0x80000004, assert trap=1, drive epc=pc and clear pending_irq, even if stall=1.
REQ-016 pending_irq SHALL stay set while kernel=1 and SHALL be taken in the first user-mode cycle.
REQ-017 A new edge arriving while pending_irq=1 SHALL be absorbed (no counting).
REQ-018 When stall=1 with no trap, pc SHALL hold and pending_irq SHALL be retained.
REQ-019 trap and epc SHALL be combinational; epc SHALL be 0 when trap=0.

Reset
REQ-020 On reset the module SHALL drive pc=0x80000000, pc_plus4=0x80000004, kernel=1, trap=0, epc=0, and clear pending_irq and the previous-irq flop.
REQ-021 Reset SHALL override any in-flight trap, stall or pending interrupt in the same cycle.

Configuration
REQ-022 With PC_ALIGN_TRAP_EN defined, a jr whose jr_addr[1:0]!=00 SHALL vector to 0x80000008 with trap=1 and epc=pc_plus4, ranked between illop and irq.
REQ-023 Without PC_ALIGN_TRAP_EN, a jr SHALL force jr_addr[1:0] to 00 and SHALL never trap.

Structure
REQ-024 Package cpu_pkg SHALL hold RESET_VEC, IRQ_VEC, EXC_VEC and the PC_SEL_* encodings.
REQ-025 Sub-module irq_edge_latch SHALL implement the previous-irq flop, edge detection and pending_irq with set/clear ports.
REQ-026 The remainder SHALL be the next-PC mux and the pc register.

Verification
REQ-027 Release reset, seq for 3 cycles -> pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
REQ-028 pc=0x00000060, pc_sel=01, branch_taken=1, imm16=0xFFFD -> next pc 0x00000058; branch_taken=0 -> next pc 0x00000064.
REQ-029 pc=0x00000064 user mode, irq rises -> pending set next edge; following cycle trap=1, epc=0x00000068 (current pc), next pc 0x80000004, kernel=1.
REQ-030 irq edge while pc=0x800000C0 -> no trap; jr jr_addr=0x00000024 -> pc 0x00000024; next cycle trap=1, epc=0x00000024, next pc 0x80000004.
REQ-031 illop=1 with pending_irq=1 at pc=0x00000010 -> next pc 0x80000008, epc=0x00000014, pending retained; stall=1 with pc_sel=10 -> pc holds.
REQ-032 jr_addr=0x00000026 -> next pc 0x80000008 with PC_ALIGN_TRAP_EN, 0x00000024 without.
